// File: rtl/dsp_fret_module.sv
// Free-entry return queue: compacts sparse per-lane RSV index releases, buffers them
// circularly and drains up to four per cycle. Optional zero-latency path: DSP_FRET_BYPASS_EN.
module dsp_fret_module #(
  parameter int DEPTH         = 16,
  parameter int RSV_IDX_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_csr_trap_flush,
  input  logic                          i_dsp_fmgr_stall,
  input  logic [3:0]                    i_fret_enq_vld,
  input  logic [RSV_IDX_WIDTH-1:0]      i_fret_enq_entry_0,
  input  logic [RSV_IDX_WIDTH-1:0]      i_fret_enq_entry_1,
  input  logic [RSV_IDX_WIDTH-1:0]      i_fret_enq_entry_2,
  input  logic [RSV_IDX_WIDTH-1:0]      i_fret_enq_entry_3,
  output logic                          o_fret_enq_rdy,
  output logic [3:0]                    o_fret_ret_vld,
  output logic [RSV_IDX_WIDTH-1:0]      o_fret_ret_entry_0,
  output logic [RSV_IDX_WIDTH-1:0]      o_fret_ret_entry_1,
  output logic [RSV_IDX_WIDTH-1:0]      o_fret_ret_entry_2,
  output logic [RSV_IDX_WIDTH-1:0]      o_fret_ret_entry_3,
  output logic [$clog2(DEPTH):0]        o_fret_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]            rd_ptr, wr_ptr;
  logic [CW-1:0]            cnt;
  logic [RSV_IDX_WIDTH-1:0] mem [DEPTH];

  logic [RSV_IDX_WIDTH-1:0] enq_ent [4];
  logic [RSV_IDX_WIDTH-1:0] ret_ent [4];
  logic [2:0]               lane_off [4];
  logic [2:0]               pop_n, enq_n, deq_n;
  logic                     rdy, drain_ok, byp, enq_acc;

  assign enq_ent[0] = i_fret_enq_entry_0;
  assign enq_ent[1] = i_fret_enq_entry_1;
  assign enq_ent[2] = i_fret_enq_entry_2;
  assign enq_ent[3] = i_fret_enq_entry_3;

  assign rdy      = (cnt <= CW'(DEPTH - 4));
  assign drain_ok = ~i_dsp_fmgr_stall & ~i_csr_trap_flush & ~rst;

`ifdef DSP_FRET_BYPASS_EN
  assign byp = drain_ok & (cnt == '0);
`else
  assign byp = 1'b0;
`endif

  assign enq_acc = rdy & ~i_csr_trap_flush & ~byp;
  assign enq_n   = enq_acc ? pop_n : 3'd0;

  // Each valid lane's slot offset is the number of valid lanes below it.
  always_comb begin
    logic [2:0] acc;
    acc = 3'd0;
    for (int k = 0; k < 4; k++) begin
      lane_off[k] = acc;
      acc = acc + {2'b00, i_fret_enq_vld[k]};
    end
    pop_n = acc;
  end

  always_comb begin
    deq_n = 3'd0;
    if (drain_ok && !byp)
      deq_n = (cnt >= CW'(4)) ? 3'd4 : cnt[2:0];
  end

  always_comb begin
    o_fret_ret_vld = 4'b0000;
    for (int k = 0; k < 4; k++) ret_ent[k] = '0;
`ifdef DSP_FRET_BYPASS_EN
    if (byp) begin
      for (int k = 0; k < 4; k++) begin
        if (i_fret_enq_vld[k]) ret_ent[lane_off[k][1:0]] = enq_ent[k];
        o_fret_ret_vld[k] = (3'(k) < pop_n);
      end
    end else
`endif
    begin
      for (int k = 0; k < 4; k++) begin
        o_fret_ret_vld[k] = (3'(k) < deq_n);
        if (o_fret_ret_vld[k]) ret_ent[k] = mem[rd_ptr + PW'(k)];
      end
    end
  end

  assign o_fret_ret_entry_0 = ret_ent[0];
  assign o_fret_ret_entry_1 = ret_ent[1];
  assign o_fret_ret_entry_2 = ret_ent[2];
  assign o_fret_ret_entry_3 = ret_ent[3];
  assign o_fret_enq_rdy     = rdy;
  assign o_fret_cnt         = cnt;

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (enq_acc && i_fret_enq_vld[k])
        mem[wr_ptr + PW'(lane_off[k])] <= enq_ent[k];
  end

  always_ff @(posedge clk) begin
    if (rst || i_csr_trap_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(deq_n);
      wr_ptr <= wr_ptr + PW'(enq_n);
      cnt    <= cnt + CW'(enq_n) - CW'(deq_n);
    end
  end
endmodule

// File: tb/tb_dsp_fret_module.sv
// Self-checking bench for dsp_fret_module against a queue-based reference model;
// define DSP_FRET_BYPASS_EN for both files to check the zero-latency variant.
module tb_dsp_fret_module;
  localparam int DEPTH = 16;
  localparam int IW    = 6;

  logic          clk = 1'b0;
  logic          rst, flush, stall;
  logic [3:0]    enq_vld;
  logic [IW-1:0] e0, e1, e2, e3;
  logic          rdy;
  logic [3:0]    ret_vld;
  logic [IW-1:0] r0, r1, r2, r3;
  logic [4:0]    cnt;
  logic [IW-1:0] obs_e [4];

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] q [$];

  always #5 clk = ~clk;

  dsp_fret_module #(.DEPTH(DEPTH), .RSV_IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .i_csr_trap_flush(flush), .i_dsp_fmgr_stall(stall),
    .i_fret_enq_vld(enq_vld),
    .i_fret_enq_entry_0(e0), .i_fret_enq_entry_1(e1),
    .i_fret_enq_entry_2(e2), .i_fret_enq_entry_3(e3),
    .o_fret_enq_rdy(rdy), .o_fret_ret_vld(ret_vld),
    .o_fret_ret_entry_0(r0), .o_fret_ret_entry_1(r1),
    .o_fret_ret_entry_2(r2), .o_fret_ret_entry_3(r3),
    .o_fret_cnt(cnt)
  );

  assign obs_e[0] = r0;
  assign obs_e[1] = r1;
  assign obs_e[2] = r2;
  assign obs_e[3] = r3;

  // One clock cycle: drive at negedge, check settled outputs, then advance the model.
  task automatic step(input logic r, input logic fl, input logic st,
                      input logic [3:0] v, input logic [4*IW-1:0] ents);
    logic [IW-1:0] lst [$];
    logic [IW-1:0] pres [$];
    logic [IW-1:0] lane [4];
    logic          byp, rdy_exp;
    logic [3:0]    vld_exp;
    logic [IW-1:0] ent_exp;
    int            n;
    @(negedge clk);
    rst = r; flush = fl; stall = st; enq_vld = v;
    for (int k = 0; k < 4; k++) lane[k] = ents[k*IW +: IW];
    e0 = lane[0]; e1 = lane[1]; e2 = lane[2]; e3 = lane[3];
    #1;
    for (int k = 0; k < 4; k++) if (v[k]) lst.push_back(lane[k]);
`ifdef DSP_FRET_BYPASS_EN
    byp = (q.size() == 0) && !st && !fl && !r;
`else
    byp = 1'b0;
`endif
    if (byp) pres = lst;
    else if (!st && !fl && !r) begin
      n = (q.size() < 4) ? q.size() : 4;
      for (int k = 0; k < n; k++) pres.push_back(q[k]);
    end
    rdy_exp = (q.size() <= DEPTH - 4);
    vld_exp = 4'((1 << pres.size()) - 1);
    if (!r) begin
      checks++;
      assert (cnt === 5'(q.size())) else begin
        errors++; $error("FAIL cnt observed=%0d expected=%0d", cnt, q.size());
      end
      checks++;
      assert (rdy === rdy_exp) else begin
        errors++; $error("FAIL rdy observed=%b expected=%b", rdy, rdy_exp);
      end
      checks++;
      assert (ret_vld === vld_exp) else begin
        errors++; $error("FAIL ret_vld observed=%b expected=%b", ret_vld, vld_exp);
      end
      for (int k = 0; k < 4; k++) begin
        ent_exp = (k < pres.size()) ? pres[k] : '0;
        checks++;
        assert (obs_e[k] === ent_exp) else begin
          errors++; $error("FAIL ret_entry_%0d observed=%0d expected=%0d", k, obs_e[k], ent_exp);
        end
      end
    end
    @(posedge clk);
    if (r || fl) q.delete();
    else if (!byp) begin
      for (int k = 0; k < pres.size(); k++) void'(q.pop_front());
      if (rdy_exp) foreach (lst[k]) q.push_back(lst[k]);
    end
  endtask

  function automatic logic [4*IW-1:0] pack4(input int base);
    return {IW'(base + 3), IW'(base + 2), IW'(base + 1), IW'(base)};
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; stall = 1'b0; enq_vld = 4'b0;
    e0 = '0; e1 = '0; e2 = '0; e3 = '0;
    step(1, 0, 0, 4'b0000, '0);
    step(1, 0, 0, 4'b0000, '0);
    step(0, 0, 0, 4'b0000, '0);

    // Sparse release on lanes 1 and 3.
    step(0, 0, 0, 4'b1010, {IW'(9), IW'(0), IW'(5), IW'(0)});
    step(0, 0, 0, 4'b0000, '0);
    step(0, 0, 0, 4'b0000, '0);

    // Fill to full under stall; extra releases are refused while full.
    for (int i = 0; i < 6; i++) step(0, 0, 1, 4'b1111, pack4(4 * i + ((i < 4) ? 0 : 30)));
    for (int i = 0; i < 5; i++) step(0, 0, 0, 4'b0000, '0);

    // Two fill/drain rounds so both pointers wrap past the end of storage.
    step(0, 0, 1, 4'b1111, pack4(20));
    step(0, 0, 1, 4'b1111, pack4(24));
    step(0, 0, 1, 4'b0011, pack4(28));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'b0000, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 4'b1111, pack4(40 + 4 * i));
    step(0, 0, 1, 4'b0101, pack4(52));
    for (int i = 0; i < 5; i++) step(0, 0, 0, 4'b0000, '0);

    // Simultaneous enqueue/drain of four at the ready threshold.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 4'b1111, pack4(4 * i + 1));
    step(0, 0, 0, 4'b1111, pack4(33));
    for (int i = 0; i < 5; i++) step(0, 0, 0, 4'b0000, '0);

    // Trap flush with seven buffered and a concurrent full release.
    step(0, 0, 1, 4'b1111, pack4(10));
    step(0, 0, 1, 4'b0111, pack4(14));
    step(0, 1, 0, 4'b1111, pack4(60));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b0000, '0);

    // Reset while draining with nine buffered.
    step(0, 0, 1, 4'b1111, pack4(1));
    step(0, 0, 1, 4'b1111, pack4(5));
    step(0, 0, 1, 4'b0001, pack4(9));
    step(1, 0, 0, 4'b0000, '0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 4'b0000, '0);

    for (int i = 0; i < 600; i++) begin
      step(1'b0, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 35),
           4'($urandom), {IW'($urandom), IW'($urandom), IW'($urandom), IW'($urandom)});
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, 4'b0000, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsp_fret_module.md
# dsp_fret_module

Free-entry return queue between the reservation-station issue logic and the dispatch free-list manager. Issue releases up to four RSV entry indices per cycle in arbitrary (sparse) lanes; this block compacts them in lane order, buffers them in a circular queue, and drains up to four per cycle as the contiguous `ret_vld`/`ret_entry` group the free-list manager consumes. It absorbs cycles where the manager is stalled and discards everything on a trap flush, because the manager rebuilds its full free map then.

## Interface
- `DEPTH`, 16, queue entries; power of two, ≥ 8.
- `clk`  input  1  clock, all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `i_csr_trap_flush`  input  1  clears the queue; overrides everything.
- `i_dsp_fmgr_stall`  input  1  manager stalled; no drain this cycle.
- `i_fret_enq_vld`  input  4  per-lane release valid from issue; may be sparse.
- `i_fret_enq_entry_0..3`  input  `RSV_IDX_WIDTH` each  released RSV index per lane.
- `o_fret_enq_rdy`  output  1  queue can accept a full 4-lane release this cycle.
- `o_fret_ret_vld`  output  4  return valid to manager; always contiguous from bit 0.
- `o_fret_ret_entry_0..3`  output  `RSV_IDX_WIDTH` each  returned index; 0 when its valid bit is low.
- `o_fret_cnt`  output  log2(DEPTH)+1  current occupancy.

## Operation
- State: `rd_ptr`, `wr_ptr` (log2(DEPTH) bits, wrap modulo DEPTH), `cnt` (log2(DEPTH)+1 bits), storage array DEPTH × `RSV_IDX_WIDTH`.
- `o_fret_enq_rdy = (cnt <= DEPTH-4)`; combinational from `cnt` only.
- Enqueue accepted when `rdy & ~flush`: valid lanes written in ascending lane order to `wr_ptr`, `wr_ptr+1`, …; `enq_n` = popcount(`i_fret_enq_vld`); `wr_ptr += enq_n`. When `rdy` is low, the whole release is ignored and issue holds it; partial acceptance never occurs.
- Drain: `deq_n = ~stall & ~flush ? min(cnt,4) : 0`; `o_fret_ret_vld[k] = (k < deq_n)`, `o_fret_ret_entry_k = mem[rd_ptr+k]` (wrapped). The manager consumes everything presented; `rd_ptr += deq_n`.
- `cnt_nxt = cnt + enq_n - deq_n`; simultaneous enqueue and drain are legal, including at `cnt == DEPTH-4` and across pointer wrap.
- Flush: outputs `ret_vld = 0` that cycle, enqueue ignored, and `rd_ptr`, `wr_ptr`, `cnt` are 0 next cycle. Storage is not cleared.
- Reset: `rd_ptr = wr_ptr = cnt = 0`; `o_fret_ret_vld = 0`, all `o_fret_ret_entry_* = 0`, `o_fret_enq_rdy = 1`, `o_fret_cnt = 0`. Reset asserted mid-operation drops all buffered entries; identical to flush.
- Order: entries leave in exactly the order they were accepted (lane order within a cycle, cycle order across cycles).

## Timing
- Without bypass: release accepted at edge N is presented on `o_fret_ret_*` in cycle N+1 at the earliest.
- Stall: held entries stay at queue head; presentation resumes the first unstalled cycle, in unchanged order.
- `o_fret_enq_rdy` and `o_fret_cnt` reflect registered `cnt`; no combinational path from `i_fret_enq_vld` to `rdy`.
- Outputs depend combinationally on `i_dsp_fmgr_stall` and `i_csr_trap_flush` (gating only).

## Configuration
- `DSP_FRET_BYPASS_EN` defined: when `cnt == 0`, `~stall`, `~flush`, the compacted current-cycle release is driven directly on `o_fret_ret_*` (zero latency) and is not written; `cnt` stays 0. If `cnt != 0` or stalled, normal enqueue applies.
- Undefined: no bypass path; minimum latency is one cycle as above.

## Test plan
- Reset, then `enq_vld = 4'b1010`, entries lane1 = 5 and lane3 = 9 -> next cycle `ret_vld = 4'b0011`, entry_0 = 5, entry_1 = 9, `cnt` returns to 0 (with bypass: same cycle, `cnt` stays 0).
- Stall held for 4 cycles while enqueuing 4 entries per cycle (0..15) -> `rdy` low once `cnt = 16`; releases stop being accepted; on release of stall, 0..15 emerge 4 per cycle in order.
- Pointer wrap: fill to `cnt = 14` with `rd_ptr = 10`, then drain -> entries returned correctly across index 15→0 with no loss or duplication.
- At `cnt = 12`, enqueue 4 and drain 4 in the same cycle -> `cnt` stays 12, `rdy` stays 1.
- Flush with `cnt = 7` and a concurrent 4-lane release -> `ret_vld = 0` that cycle, next cycle `cnt = 0`, `rdy = 1`, and no released index is ever returned.
- Reset asserted mid-drain with `cnt = 9` -> next cycle all outputs at reset values.
